// File: rtl/fetch_unit.sv
// Instruction fetch with a one-entry hold buffer and halt detection.
// Fetch-to-valid latency 1 cycle; instr_ready low freezes the buffer and stops fetching.
module fetch_unit #(
   parameter logic [21:0] RESET_PC = 22'd100,
   parameter logic [4:0]  HALT_OP  = 5'b11111
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [21:0] mem_address,
   output logic        mem_read,
   input  logic [31:0] mem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [4:0]  opcode,
   output logic [4:0]  rd,
   output logic [21:0] addr,
   output logic [21:0] instr_pc,
   input  logic        redirect,
   input  logic [21:0] redirect_pc,
   output logic        halted
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [21:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [21:0] instr_pc_q, instr_pc_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;
   logic        held_halt;
   logic        fetch;

   assign held_halt = (instr_q[31:27] == HALT_OP);

   // A held non-halt instruction being accepted frees the buffer for a same-cycle refetch.
   assign fetch = !redirect &&
                  ((state_q == S_FETCH) ||
                   (state_q == S_HOLD && instr_ready && !held_halt));

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      if (redirect) begin
         state_d = S_FETCH;
         pc_d    = redirect_pc;
      end else if (fetch) begin
         state_d    = S_HOLD;
         instr_d    = mem_rdata;
         instr_pc_d = pc_q;
         pc_d       = pc_q + 22'd1;
      end else if (state_q == S_HOLD && instr_ready && held_halt) begin
         state_d = S_HALT;
      end
      valid_d  = (state_d == S_HOLD);
      halted_d = (state_d == S_HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
      end
   end

   assign mem_address = pc_q;
   assign mem_read    = fetch;
   assign instr_valid = valid_q;
   assign halted      = halted_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[31:27];
   assign rd          = instr_q[26:22];
   assign addr        = instr_q[21:0];
   assign instr_pc    = instr_pc_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 100, SHALL set the program-counter value loaded on reset (start of program memory).
REQ-002 Parameter HALT_OP, default 5'b11111, SHALL set the opcode that stops fetching.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous and active-low.
REQ-005 mem_address  output  22  SHALL carry the word address driven to the memory.
REQ-006 mem_read  output  1  SHALL be the memory read strobe.
REQ-007 mem_rdata  input  32  SHALL carry the memory data output, valid combinationally in the same cycle as mem_read.
REQ-008 instr_valid  output  1  SHALL mean the held instruction is valid downstream.
REQ-009 instr_ready  input  1  SHALL mean downstream accepts the held instruction this cycle.
REQ-010 instr  output  32  SHALL carry the held instruction word.
REQ-011 opcode  output  5  SHALL equal instr[31:27].
REQ-012 rd  output  5  SHALL equal instr[26:22].
REQ-013 addr  output  22  SHALL equal instr[21:0].
REQ-014 instr_pc  output  22  SHALL carry the address the held instruction was fetched from.
REQ-015 redirect  input  1  SHALL request a jump to redirect_pc.
REQ-016 redirect_pc  input  22  SHALL carry the jump target.
REQ-017 halted  output  1  SHALL be high while in state HALT.

Function
REQ-018 The block SHALL implement states FETCH, HOLD and HALT, plus internal registers pc[21:0] and a one-entry instruction buffer.
REQ-019 The memory SHALL be driven with mem_address = pc and mem_read = 1 exactly when (state==FETCH) or (state==HOLD and instr_ready and opcode!=HALT_OP), with redirect low; otherwise mem_read = 0 and mem_address = pc.
REQ-020 On an edge with mem_read = 1, the block SHALL capture instr <= mem_rdata, set instr_pc <= pc, set pc <= pc+1 and enter or remain in HOLD; fetch-to-valid latency SHALL be 1 cycle.
REQ-021 instr_valid SHALL be 1 exactly in HOLD; instr, instr_pc and fields SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-022 HOLD with instr_ready=1 and opcode!=HALT_OP SHALL accept and refetch in the same cycle, sustaining 1 instruction per cycle.
REQ-023 HOLD with instr_ready=1 and opcode==HALT_OP SHALL go to HALT with no further fetch; pc SHALL be left at the halt address + 1.
REQ-024 HALT SHALL hold mem_read=0 and instr_valid=0 until reset or redirect.
REQ-025 redirect=1 in any state SHALL take priority: pc <= redirect_pc, the buffer is discarded, and state goes to FETCH; instr_valid SHALL be 0 the next cycle.
REQ-026 pc increment SHALL wrap from 22'h3FFFFF to 0 with no error indication.
REQ-027 redirect with instr_ready=1 in the same cycle SHALL count as accepted by downstream; the redirect still wins for next-state.

Reset
REQ-028 While rst_n=0, regardless of clk: state=FETCH, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0.
REQ-029 Reset asserted mid-operation (any state) SHALL abort immediately; the first fetch after release SHALL be from RESET_PC.

Verification
REQ-030 Reset release, memory with mem[100]=32'h80000000 and mem[101]=32'h80400001, instr_ready=1 -> cycle 1 mem_address=100; cycle 2 instr_valid=1, opcode=5'b10000, rd=0, addr=0, instr_pc=100; cycle 3 rd=1, addr=1, instr_pc=101.
REQ-031 instr_ready=0 for 3 cycles while in HOLD at instr_pc=101 -> instr stable, mem_read=0, pc=102; on ready=1, next instr_pc=102.
REQ-032 mem[103]={HALT_OP,27'b0}, instr_ready=1 -> mem_read=0 while the halt is held; after acceptance halted=1 and instr_valid=0 for 10+ cycles.
REQ-033 In HALT, redirect=1 with redirect_pc=100 -> halted=0 next cycle, then instr_pc=100 delivered one cycle later.
REQ-034 redirect_pc=22'h3FFFFF, instr_ready=1 -> instr_pc sequence 3FFFFF, 000000, 000001.
REQ-035 rst_n pulsed low asynchronously mid-HOLD -> instr_valid=0 immediately, without a clk edge; after release first mem_address=100.
